// File: rtl/instruction_fetch.sv
// instruction_fetch: sequential fetch from a combinational command cache into a
// small {pc, instr} FIFO toward decode, with redirect (flush + restart).
// Optional macro IFETCH_MISALIGN_TRAP_EN: a misaligned redirect target traps into
// a sticky FAULT state (fault/fault_pc); without it the target is word-aligned.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] cmd_address,
   input  logic [31:0] cmd_content,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   output logic        fault,
   output logic [31:0] fault_pc
);

   // BUF_DEPTH is a power of two, so pointers wrap by natural overflow
   localparam int unsigned PW = $clog2(BUF_DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_FAULT = 1'b1
   } state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   state_t          state_q, state_d;
   logic [31:0]     pc_q;
   logic [CW-1:0]   count_q;
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   entry_t          buf_q [BUF_DEPTH];

   logic            misalign;
   logic            redir_take;
   logic            push, pop;
   logic [31:0]     target_aligned;

   // low target bits are dropped on every pc load; misalignment is decided separately
   assign target_aligned = redirect_target & 32'hFFFF_FFFC;

`ifdef IFETCH_MISALIGN_TRAP_EN
   assign misalign = (redirect_target[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif

   assign cmd_address = pc_q;

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ST_RUN;
      else        state_q <= state_d;
   end

   // next state and handshake decode; redirect beats push, pop and full
   always_comb begin
      state_d    = state_q;
      redir_take = 1'b0;
      push       = 1'b0;
      pop        = 1'b0;
      out_valid  = 1'b0;
      case (state_q)
         ST_RUN: begin
            out_valid  = (count_q != '0);
            redir_take = redirect;
            pop        = out_valid & out_ready & ~redirect;
            push       = ~redirect & ((count_q < CW'(BUF_DEPTH)) | pop);
            if (redirect && misalign) state_d = ST_FAULT;
         end
         ST_FAULT: begin
            // parked until reset; redirects are ignored here
            state_d = ST_FAULT;
         end
         default: state_d = ST_RUN;
      endcase
   end

   // fetch pointer: reset, redirect reload, or advance on every push
   always_ff @(posedge clk) begin
      if (!rst_n)                     pc_q <= RESET_PC;
      else if (redir_take && !misalign) pc_q <= target_aligned;
      else if (push)                  pc_q <= pc_q + 32'd4;
   end

   // occupancy and pointers; a redirect (taken or trapping) flushes everything
   always_ff @(posedge clk) begin
      if (!rst_n || redir_take) begin
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // storage: each entry captures {pc, cache word} when it is the write target
   for (genvar g = 0; g < BUF_DEPTH; g++) begin : g_buf
      always_ff @(posedge clk) begin
         if (push && (wr_ptr_q == PW'(g))) buf_q[g] <= '{pc: pc_q, instr: cmd_content};
      end
   end

   assign out_pc    = buf_q[rd_ptr_q].pc;
   assign out_instr = buf_q[rd_ptr_q].instr;

`ifdef IFETCH_MISALIGN_TRAP_EN
   logic        fault_q;
   logic [31:0] fault_pc_q;

   // sticky trap record of the first misaligned redirect
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fault_q    <= 1'b0;
         fault_pc_q <= '0;
      end else if (redir_take && misalign) begin
         fault_q    <= 1'b1;
         fault_pc_q <= redirect_target;
      end
   end

   assign fault    = fault_q;
   assign fault_pc = fault_pc_q;
`else
   assign fault    = 1'b0;
   assign fault_pc = 32'h0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: main instance at default parameters plus a
// second instance at RESET_PC=FFFF_FFF8, BUF_DEPTH=4 for wrap behaviour.
module tb_instruction_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        out_ready;
   logic        redirect;
   logic [31:0] redirect_target;
   logic [31:0] cmd_address, cmd_content, out_pc, out_instr, fault_pc;
   logic        out_valid, fault;

   logic        hi_ready;
   logic        hi_redirect;
   logic [31:0] hi_target;
   logic [31:0] hi_cmd_address, hi_cmd_content, hi_out_pc, hi_out_instr, hi_fault_pc;
   logic        hi_out_valid, hi_fault;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   // cache contents: a recognisable word per address
   function automatic logic [31:0] mem(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   assign cmd_content    = mem(cmd_address);
   assign hi_cmd_content = mem(hi_cmd_address);

   instruction_fetch u_dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_address(cmd_address), .cmd_content(cmd_content),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_instr(out_instr),
      .redirect(redirect), .redirect_target(redirect_target),
      .fault(fault), .fault_pc(fault_pc)
   );

   instruction_fetch #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(4)) u_dut_hi (
      .clk(clk), .rst_n(rst_n),
      .cmd_address(hi_cmd_address), .cmd_content(hi_cmd_content),
      .out_valid(hi_out_valid), .out_ready(hi_ready),
      .out_pc(hi_out_pc), .out_instr(hi_out_instr),
      .redirect(hi_redirect), .redirect_target(hi_target),
      .fault(hi_fault), .fault_pc(hi_fault_pc)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // two reset edges, then release; returns in the first cycle after release
   task automatic do_reset();
      rst_n    = 1'b0;
      redirect = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      out_ready = 1'b1;
      rst_n = 1'b0;
      redirect = 1'b1;
      redirect_target = 32'h0000_0100;
      tick();
      tick();
      n_tests++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
      n_tests++;
      if (cmd_address !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 00000000", cmd_address); end
      n_tests++;
      if (fault !== 1'b0 || fault_pc !== 32'h0) begin n_fail++; $display("FAIL reset_fault: got %b/%h expected 0/00000000", fault, fault_pc); end
      redirect = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_stream();
      logic [31:0] e;
      out_ready = 1'b1;
      do_reset();
      n_tests++;
      if (out_valid !== 1'b0 || cmd_address !== 32'h0) begin n_fail++; $display("FAIL stream_c0: got valid=%b addr=%h expected 0/00000000", out_valid, cmd_address); end
      for (int i = 0; i < 5; i++) begin
         tick();
         e = 32'(4 * i);
         n_tests++;
         if (out_valid !== 1'b1 || out_pc !== e || out_instr !== mem(e)) begin
            n_fail++;
            $display("FAIL stream_%0d: got v=%b pc=%h ins=%h expected 1/%h/%h", i, out_valid, out_pc, out_instr, e, mem(e));
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] e;
      out_ready = 1'b0;
      do_reset();
      for (int i = 0; i < 6; i++) tick();
      n_tests++;
      if (out_valid !== 1'b1 || out_pc !== 32'h0 || cmd_address !== 32'h8) begin
         n_fail++;
         $display("FAIL bp_full: got v=%b pc=%h addr=%h expected 1/00000000/00000008", out_valid, out_pc, cmd_address);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         e = 32'(4 * i);
         n_tests++;
         if (out_valid !== 1'b1 || out_pc !== e || out_instr !== mem(e)) begin
            n_fail++;
            $display("FAIL bp_drain_%0d: got v=%b pc=%h ins=%h expected 1/%h/%h", i, out_valid, out_pc, out_instr, e, mem(e));
         end
         tick();
      end
   endtask

   task automatic test_redirect();
      out_ready = 1'b0;
      do_reset();
      tick();
      tick();
      n_tests++;
      if (out_valid !== 1'b1 || cmd_address !== 32'h8) begin n_fail++; $display("FAIL redir_pre: got v=%b addr=%h expected 1/00000008", out_valid, cmd_address); end
      out_ready = 1'b1;
      redirect = 1'b1;
      redirect_target = 32'h0000_0040;
      tick();
      redirect = 1'b0;
      n_tests++;
      if (out_valid !== 1'b0 || cmd_address !== 32'h40) begin n_fail++; $display("FAIL redir_n1: got v=%b addr=%h expected 0/00000040", out_valid, cmd_address); end
      tick();
      n_tests++;
      if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_instr !== mem(32'h40)) begin n_fail++; $display("FAIL redir_n2: got v=%b pc=%h ins=%h expected 1/00000040/%h", out_valid, out_pc, out_instr, mem(32'h40)); end
      tick();
      n_tests++;
      if (out_valid !== 1'b1 || out_pc !== 32'h44) begin n_fail++; $display("FAIL redir_n3: got v=%b pc=%h expected 1/00000044", out_valid, out_pc); end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      do_reset();
      tick();
      tick();
      redirect = 1'b1;
      redirect_target = 32'h0000_0200;
      tick();
      redirect_target = 32'h0000_0300;
      tick();
      redirect = 1'b0;
      n_tests++;
      if (out_valid !== 1'b0 || cmd_address !== 32'h300) begin n_fail++; $display("FAIL b2b_n1: got v=%b addr=%h expected 0/00000300", out_valid, cmd_address); end
      tick();
      n_tests++;
      if (out_valid !== 1'b1 || out_pc !== 32'h300) begin n_fail++; $display("FAIL b2b_n2: got v=%b pc=%h expected 1/00000300", out_valid, out_pc); end
   endtask

   task automatic test_misalign();
      out_ready = 1'b1;
      do_reset();
      tick();
      tick();
      redirect = 1'b1;
      redirect_target = 32'h0000_0042;
      tick();
      redirect = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
      n_tests++;
      if (fault !== 1'b1 || fault_pc !== 32'h42 || out_valid !== 1'b0) begin n_fail++; $display("FAIL trap_enter: got f=%b fpc=%h v=%b expected 1/00000042/0", fault, fault_pc, out_valid); end
      redirect = 1'b1;
      redirect_target = 32'h0000_0080;
      tick();
      redirect = 1'b0;
      tick();
      tick();
      n_tests++;
      if (fault !== 1'b1 || fault_pc !== 32'h42 || out_valid !== 1'b0) begin n_fail++; $display("FAIL trap_hold: got f=%b fpc=%h v=%b expected 1/00000042/0", fault, fault_pc, out_valid); end
`else
      n_tests++;
      if (fault !== 1'b0 || out_valid !== 1'b0 || cmd_address !== 32'h40) begin n_fail++; $display("FAIL align_n1: got f=%b v=%b addr=%h expected 0/0/00000040", fault, out_valid, cmd_address); end
      tick();
      n_tests++;
      if (out_valid !== 1'b1 || out_pc !== 32'h40 || fault_pc !== 32'h0) begin n_fail++; $display("FAIL align_n2: got v=%b pc=%h fpc=%h expected 1/00000040/00000000", out_valid, out_pc, fault_pc); end
`endif
   endtask

   task automatic test_midreset();
      out_ready = 1'b0;
      do_reset();
      tick();
      tick();
      tick();
      out_ready = 1'b1;
      redirect = 1'b1;
      redirect_target = 32'h0000_0100;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      redirect = 1'b0;
      n_tests++;
      if (out_valid !== 1'b0 || fault !== 1'b0 || cmd_address !== 32'h0) begin n_fail++; $display("FAIL midrst_c0: got v=%b f=%b addr=%h expected 0/0/00000000", out_valid, fault, cmd_address); end
      tick();
      n_tests++;
      if (out_valid !== 1'b1 || out_pc !== 32'h0 || fault !== 1'b0) begin n_fail++; $display("FAIL midrst_c1: got v=%b pc=%h f=%b expected 1/00000000/0", out_valid, out_pc, fault); end
      tick();
      n_tests++;
      if (out_valid !== 1'b1 || out_pc !== 32'h4) begin n_fail++; $display("FAIL midrst_c2: got v=%b pc=%h expected 1/00000004", out_valid, out_pc); end
   endtask

   task automatic test_wrap();
      logic [31:0] e;
      hi_ready = 1'b0;
      do_reset();
      n_tests++;
      if (hi_out_valid !== 1'b0 || hi_cmd_address !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL wrap_c0: got v=%b addr=%h expected 0/fffffff8", hi_out_valid, hi_cmd_address); end
      for (int i = 0; i < 6; i++) tick();
      n_tests++;
      if (hi_cmd_address !== 32'h8 || hi_out_pc !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL wrap_full: got addr=%h pc=%h expected 00000008/fffffff8", hi_cmd_address, hi_out_pc); end
      hi_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         e = 32'hFFFF_FFF8 + 32'(4 * i);
         n_tests++;
         if (hi_out_valid !== 1'b1 || hi_out_pc !== e || hi_out_instr !== mem(e) || hi_fault !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_%0d: got v=%b pc=%h ins=%h expected 1/%h/%h", i, hi_out_valid, hi_out_pc, hi_out_instr, e, mem(e));
         end
         tick();
      end
   endtask

   initial begin
      rst_n = 1'b0;
      out_ready = 1'b1;
      redirect = 1'b0;
      redirect_target = 32'h0;
      hi_ready = 1'b1;
      hi_redirect = 1'b0;
      hi_target = 32'h0;
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_back_to_back();
      test_misalign();
      test_midreset();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, word-aligned fetch address loaded on reset.
REQ-002 Parameter BUF_DEPTH, default 2, fetch-buffer entries; legal values 2, 4, 8.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 cmd_address  output  32  byte address presented to the combinational command cache.
REQ-006 cmd_content  input  32  instruction word returned by the cache in the same cycle as cmd_address.
REQ-007 out_valid  output  1  head buffer entry valid toward decode.
REQ-008 out_ready  input  1  decode accepts head entry.
REQ-009 out_pc  output  32  address of head entry.
REQ-010 out_instr  output  32  instruction word of head entry.
REQ-011 redirect  input  1  one-cycle pulse: discard buffered work, restart fetch at redirect_target.
REQ-012 redirect_target  input  32  new fetch address, sampled when redirect=1.
REQ-013 fault  output  1  sticky misaligned-redirect flag (see Configuration).
REQ-014 fault_pc  output  32  offending redirect_target captured at fault.

Function
REQ-015 Internal state: pc register, BUF_DEPTH-entry FIFO of {pc, instr}, count, state in {RUN, FAULT}.
REQ-016 cmd_address SHALL equal pc combinationally at all times.
REQ-017 push = (state==RUN) & ~redirect & (count<BUF_DEPTH | pop); pushed entry = {pc, cmd_content}; pc <= pc+4 on push.
REQ-018 pop = out_valid & out_ready & ~redirect; push and pop in the same cycle SHALL leave count unchanged.
REQ-019 out_valid = (count!=0); out_pc/out_instr = head entry; head SHALL hold stable while out_valid & ~out_ready.
REQ-020 Latency: instruction at pc fetched in cycle N SHALL appear at head no earlier than cycle N+1.
REQ-021 Full (count==BUF_DEPTH) and ~out_ready: no push, pc holds, cmd_address holds.
REQ-022 redirect=1 in cycle N: FIFO flushed (count<=0), pc <= target, no push/pop in N; target fetched in N+1; out_valid=1 with out_pc=target in N+2.
REQ-023 redirect SHALL take priority over simultaneous pop, push, and full condition.
REQ-024 pc increment SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-025 FIFO read/write pointers SHALL wrap modulo BUF_DEPTH.

Reset
REQ-026 While rst_n=0 at a rising edge: pc<=RESET_PC, count<=0, pointers<=0, state<=RUN, fault<=0, fault_pc<=0.
REQ-027 Reset SHALL override redirect and all handshakes; out_valid=0 in the first cycle after reset release, fetch of RESET_PC in that cycle.
REQ-028 Reset asserted mid-stream SHALL discard all buffered entries; no entry from before reset appears afterward.

Configuration
REQ-029 Macro IFETCH_MISALIGN_TRAP_EN defined: redirect with redirect_target[1:0]!=0 SHALL flush FIFO, set fault=1, fault_pc<=target, state<=FAULT; FAULT stops all pushes, out_valid=0; exit only by reset; redirect ignored in FAULT.
REQ-030 Macro undefined: redirect_target[1:0] SHALL be forced to 2'b00 before loading pc; FAULT state absent; fault and fault_pc tied to 0.

Verification
REQ-031 Reset release, out_ready=1, cache holds 5 words at 0x0..0x10 -> out_pc 0x0,0x4,0x8,0xC,0x10 on consecutive cycles starting cycle 1, matching words.
REQ-032 out_ready=0 for 6 cycles after reset -> count reaches BUF_DEPTH=2, cmd_address stops at 0x8, head stays pc 0x0; out_ready=1 -> no loss/duplication.
REQ-033 redirect to 0x40 while 2 entries buffered and out_ready=1 -> no pop that cycle, out_valid=0 next cycle, out_pc=0x40 two cycles after redirect.
REQ-034 RESET_PC=32'hFFFF_FFF8 -> out_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-035 With IFETCH_MISALIGN_TRAP_EN, redirect to 0x42 -> fault=1, fault_pc=0x42, out_valid=0 until reset; without macro -> out_pc=0x40.
REQ-036 rst_n=0 for one cycle mid-stream with full buffer -> next valid entry has out_pc=RESET_PC, fault=0.
